// File: rtl/demux_8x1.sv
// 1-to-8 demultiplexer: steers A onto lane d[s], all other lanes zero.
// REG_OUT selects a registered (1-cycle latency) or purely combinational output.
module demux_8x1 #(
  parameter bit REG_OUT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       A,
  input  logic [2:0] s,
  output logic [7:0] d
);

  logic [7:0] w_next_d;
  logic [7:0] r_d;

  // Full case with a zero default so out-of-contract selects never hold state.
  always_comb begin
    w_next_d = 8'h00;
    case (s)
      3'd0:    w_next_d = {7'b0, A};
      3'd1:    w_next_d = {6'b0, A, 1'b0};
      3'd2:    w_next_d = {5'b0, A, 2'b0};
      3'd3:    w_next_d = {4'b0, A, 3'b0};
      3'd4:    w_next_d = {3'b0, A, 4'b0};
      3'd5:    w_next_d = {2'b0, A, 5'b0};
      3'd6:    w_next_d = {1'b0, A, 6'b0};
      3'd7:    w_next_d = {A, 7'b0};
      default: w_next_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_d <= 8'h00;
    end else begin
      r_d <= w_next_d;
    end
  end

  // The register is optimised away when the output is combinational.
  assign d = REG_OUT ? r_d : w_next_d;

endmodule

// File: tb/tb_demux_8x1.sv
// Self-checking bench for demux_8x1: registered and combinational variants
// driven by directed and randomized stimulus against a behavioural model.
module tb_demux_8x1;

  logic       clk;
  logic       rst;
  logic       a_in;
  logic [2:0] s_in;
  logic [7:0] d_reg;
  logic [7:0] d_comb;

  int checks;
  int failures;

  // Expected registered output, updated at each rising edge from applied inputs.
  logic [7:0] m_d;

  demux_8x1 #(.REG_OUT(1'b1)) u_dut_reg (
    .clk (clk),
    .rst (rst),
    .A   (a_in),
    .s   (s_in),
    .d   (d_reg)
  );

  demux_8x1 #(.REG_OUT(1'b0)) u_dut_comb (
    .clk (clk),
    .rst (rst),
    .A   (a_in),
    .s   (s_in),
    .d   (d_comb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] lane_value(input logic a, input logic [2:0] sel);
    int unsigned v;
    v = a ? (2 ** int'(sel)) : 0;
    return v[7:0];
  endfunction

  // Drive inputs, advance one rising edge, update the model, settle 1 time unit.
  task automatic apply(input logic r, input logic a, input logic [2:0] sel);
    rst  = r;
    a_in = a;
    s_in = sel;
    @(posedge clk);
    m_d = r ? 8'h00 : lane_value(a, sel);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 1'b1, 3'b101);
      checks++;
      if (d_reg !== 8'h00) begin
        failures++;
        $display("FAIL reset_hold[%0d] d=%h required=%h", i, d_reg, 8'h00);
      end
    end
  endtask

  task automatic test_sweep_a1();
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 1'b1, 3'(i));
      checks++;
      if (d_reg !== (8'h01 << i)) begin
        failures++;
        $display("FAIL sweep_a1[s=%0d] d=%h required=%h", i, d_reg, 8'h01 << i);
      end
    end
  endtask

  task automatic test_sweep_a0();
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 1'b0, 3'(i));
      checks++;
      if (d_reg !== 8'h00) begin
        failures++;
        $display("FAIL sweep_a0[s=%0d] d=%h required=%h", i, d_reg, 8'h00);
      end
    end
  endtask

  task automatic test_alternate();
    logic [7:0] exp_d;
    for (int i = 0; i < 16; i++) begin
      apply(1'b0, 1'(i % 2), 3'(i / 2));
      exp_d = (i % 2 == 1) ? (8'h01 << (i / 2)) : 8'h00;
      checks++;
      if (d_reg !== exp_d) begin
        failures++;
        $display("FAIL alternate[%0d] d=%h required=%h", i, d_reg, exp_d);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_seq [3];
    exp_seq = '{8'h40, 8'h00, 8'h40};
    for (int i = 0; i < 3; i++) begin
      apply(i == 1, 1'b1, 3'b110);
      checks++;
      if (d_reg !== exp_seq[i]) begin
        failures++;
        $display("FAIL reset_mid[%0d] d=%h required=%h", i, d_reg, exp_seq[i]);
      end
    end
  endtask

  task automatic test_comb();
    // Change inputs between edges; the combinational variant follows at once.
    @(negedge clk);
    a_in = 1'b1;
    s_in = 3'b011;
    #1;
    checks++;
    if (d_comb !== 8'h08) begin
      failures++;
      $display("FAIL comb_no_edge d=%h required=%h", d_comb, 8'h08);
    end
    for (int i = 0; i < 16; i++) begin
      a_in = 1'($urandom_range(1));
      s_in = 3'($urandom_range(7));
      rst  = 1'($urandom_range(1));
      #1;
      checks++;
      if (d_comb !== lane_value(a_in, s_in)) begin
        failures++;
        $display("FAIL comb_rand[%0d] d=%h required=%h", i, d_comb, lane_value(a_in, s_in));
      end
    end
  endtask

  task automatic test_random();
    logic r;
    for (int i = 0; i < 200; i++) begin
      r = ($urandom_range(9) == 0);
      apply(r, 1'($urandom_range(1)), 3'($urandom_range(7)));
      checks++;
      if (d_reg !== m_d) begin
        failures++;
        $display("FAIL random_reg[%0d] d=%h required=%h", i, d_reg, m_d);
      end
      checks++;
      if (d_comb !== lane_value(a_in, s_in)) begin
        failures++;
        $display("FAIL random_comb[%0d] d=%h required=%h", i, d_comb, lane_value(a_in, s_in));
      end
    end
  endtask

  // Invariant on every falling edge: both outputs all-zero or one-hot.
  always @(negedge clk) begin
    if (rst !== 1'bx) begin
      checks++;
      if ($countones(d_reg) > 1 || $countones(d_comb) > 1 || $isunknown({d_reg, d_comb})) begin
        failures++;
        $display("FAIL onehot d_reg=%h d_comb=%h required=zero_or_onehot", d_reg, d_comb);
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'bx;
    a_in     = 1'b0;
    s_in     = 3'b000;
    m_d      = 8'h00;
    #2;
    test_reset();
    test_sweep_a1();
    test_sweep_a0();
    test_alternate();
    test_reset_mid();
    test_comb();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
